// File: rtl/uart_apb_master.sv
// uart_apb_master: valid/ready request to APB SETUP/ACCESS initiator.
// Handles PREADY wait states and aborts stalled transfers with a timeout.
module uart_apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW:0] TO_V = (CW + 1)'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;

    // Ready depends on state only, never on req_valid.
    assign req_ready = (state == IDLE);

    // Wait-cycle count including the current low-PREADY cycle.
    assign cnt_inc = {1'b0, cnt} + (CW + 1)'(1);

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        PWRITE <= req_write;
                        PADDR  <= req_addr;
                        PWDATA <= req_wdata;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt_inc[CW-1:0];
                        if (TIMEOUT != 0 && cnt_inc == TO_V) begin
                            rsp_rdata   <= '0;
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            PSEL        <= 1'b0;
                            PENABLE     <= 1'b0;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// tb_uart_apb_master: directed table, corner sequences and random
// transfers against a transaction-level reference model.
module tb_uart_apb_master;

    localparam int TO = 4;

    logic        PCLK;
    logic        PRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int passed = 0;
    int total  = 0;

    // Completer model: memory plus programmable wait states.
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    int acc_cnt;
    int waits_cfg;

    uart_apb_master #(
        .ADDR_W (8),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    assign PREADY = PSEL && PENABLE && (acc_cnt >= waits_cfg);
    assign PRDATA = mem[PADDR];

    // Count elapsed ACCESS cycles and perform completed writes.
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Transaction-level expectation: outcome decided by wait count alone.
    task automatic model(input bit w, input logic [7:0] a,
                         input logic [31:0] d, input int waits,
                         output bit to, output logic [31:0] rd,
                         output int lat);
        if (TO != 0 && waits >= TO) begin
            to  = 1'b1;
            rd  = 32'h0;
            lat = TO + 1;
        end else begin
            to  = 1'b0;
            rd  = w ? 32'h0 : ref_mem[a];
            lat = waits + 2;
            if (w) ref_mem[a] = d;
        end
    endtask

    task automatic do_xfer(input bit w, input logic [7:0] a,
                           input logic [31:0] d, input int waits,
                           input bit e_to, input logic [31:0] e_rd,
                           input int e_lat);
        int cyc;
        int ns;
        int ne;
        bit stable;
        chk("ready_before", {31'b0, req_ready}, 32'h1);
        waits_cfg = waits;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
        cyc = 0;
        ns = 0;
        ne = 0;
        stable = 1'b1;
        while (!rsp_valid && cyc < 50) begin
            if (PSEL) begin
                ns++;
                if (PADDR !== a || PWDATA !== d || PWRITE !== w) stable = 0;
            end
            if (PENABLE) ne++;
            req_valid = (cyc == 0);
            req_write = ~w;
            req_addr  = 8'($urandom);
            req_wdata = $urandom;
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        chk("latency", cyc, e_lat);
        chk("psel_cycles", ns, e_lat);
        chk("penable_cycles", ne, e_lat - 1);
        chk("apb_stable", {31'b0, stable}, 32'h1);
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e_to});
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("psel_off", {30'b0, PSEL, PENABLE}, 32'h0);
        tick();
        chk("rsp_pulse_end", {31'b0, rsp_valid}, 32'h0);
        chk("rdata_hold", rsp_rdata, e_rd);
        chk("paddr_hold", {24'b0, PADDR}, {24'b0, a});
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;
        bit          to;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit          m_to;
        logic [31:0] m_rd;
        int          m_lat;
        int          t;
        int          rise0;
        int          rise1;
        int          nrsp;
        bit          prev;
        bit          rdy_ok;
        logic [31:0] r0;
        logic [31:0] r1;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        waits_cfg = 0;
        acc_cnt   = 0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h0;
        req_wdata = 32'h0;
        PRESETn   = 1'b0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_apb", {29'b0, PSEL, PENABLE, PWRITE}, 32'h0);
        chk("rst_addr", {24'b0, PADDR}, 32'h0);
        chk("rst_wdata", PWDATA, 32'h0);
        chk("rst_rsp", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_timeout", {31'b0, rsp_timeout}, 32'h0);
        tick();
        tick();
        PRESETn = 1'b1;
        tick();

        tbl[0] = '{1'b1, 8'h00, 32'h000000A5, 0, 1'b0, 32'h0, 2};
        tbl[1] = '{1'b0, 8'h00, 32'h0, 0, 1'b0, 32'hA5, 2};
        tbl[2] = '{1'b1, 8'h04, 32'h00000002, 1, 1'b0, 32'h0, 3};
        tbl[3] = '{1'b0, 8'h04, 32'h0, 3, 1'b0, 32'h2, 5};
        tbl[4] = '{1'b0, 8'h00, 32'h0, 100, 1'b1, 32'h0, 5};
        tbl[5] = '{1'b0, 8'h00, 32'h0, 3, 1'b0, 32'hA5, 5};
        tbl[6] = '{1'b1, 8'h00, 32'h00000077, 4, 1'b1, 32'h0, 5};
        tbl[7] = '{1'b0, 8'h00, 32'h0, 0, 1'b0, 32'hA5, 2};
        for (int i = 0; i < 8; i++) begin
            model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits,
                  m_to, m_rd, m_lat);
            do_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits,
                    tbl[i].to, tbl[i].rd, tbl[i].lat);
        end

        // Back-to-back: req_valid held high across two requests.
        waits_cfg = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h00;
        req_wdata = 32'h11;
        ref_mem[0] = 32'h11;
        tick();
        req_write = 1'b0;
        req_wdata = 32'h0;
        t = 0;
        rise0 = -1;
        rise1 = -1;
        nrsp = 0;
        prev = 1'b0;
        rdy_ok = 1'b1;
        r0 = 32'hFFFFFFFF;
        r1 = 32'hFFFFFFFF;
        while (t < 20) begin
            if (PSEL && !prev) begin
                if (rise0 < 0) rise0 = t;
                else if (rise1 < 0) begin
                    rise1 = t;
                    req_valid = 1'b0;
                end
            end
            if (req_ready === (PSEL || rsp_valid)) rdy_ok = 1'b0;
            if (rsp_valid) begin
                if (nrsp == 0) r0 = rsp_rdata;
                if (nrsp == 1) r1 = rsp_rdata;
                nrsp++;
            end
            prev = PSEL;
            tick();
            t++;
        end
        req_valid = 1'b0;
        chk("b2b_interval", rise1 - rise0, 4);
        chk("b2b_rsp_count", nrsp, 2);
        chk("b2b_ready_low", {31'b0, rdy_ok}, 32'h1);
        chk("b2b_rsp0", r0, 32'h0);
        chk("b2b_rsp1", r1, 32'h11);

        // Random transfers against the reference model.
        for (int i = 0; i < 40; i++) begin
            bit          w;
            logic [7:0]  a;
            logic [31:0] d;
            int          wt;
            w  = 1'($urandom);
            a  = 8'($urandom_range(0, 7));
            d  = $urandom;
            wt = $urandom_range(0, 6);
            model(w, a, d, wt, m_to, m_rd, m_lat);
            do_xfer(w, a, d, wt, m_to, m_rd, m_lat);
        end

        // Reset during ACCESS: outputs clear without a clock edge.
        waits_cfg = 100;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h03;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_penable", {31'b0, PENABLE}, 32'h1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_apb", {30'b0, PSEL, PENABLE}, 32'h0);
        chk("mid_rst_rsp", {31'b0, rsp_valid}, 32'h0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'h1);
        chk("mid_rst_addr", {24'b0, PADDR}, 32'h0);
        tick();
        #4;
        PRESETn = 1'b1;
        nrsp = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid || PSEL) nrsp++;
        end
        chk("no_stale_rsp", nrsp, 0);
        chk("ready_after_rst", {31'b0, req_ready}, 32'h1);
        model(1'b0, 8'h00, 32'h0, 1, m_to, m_rd, m_lat);
        do_xfer(1'b0, 8'h00, 32'h0, 1, m_to, m_rd, m_lat);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
